// File: rtl/wb_pkg.sv
// Shared Wibhbone B3 encodings, slave FSM states and the burst address helper
// for the on-chip SRAM responder.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACK, WAIT, ERR} wb_state_e;

  // Word-index successor: wrapped bursts only step the low 2/3/4 bits.
  function automatic logic [31:0] next_burst_addr(input logic [31:0] addr,
                                                  input logic [1:0]  bte);
    logic [31:0] mask;
    case (bte)
      BTE_WRAP4:  mask = 32'd3;
      BTE_WRAP8:  mask = 32'd7;
      BTE_WRAP16: mask = 32'd15;
      default:    mask = 32'hFFFF_FFFF;
    endcase
    return (addr & ~mask) | ((addr + 32'd1) & mask);
  endfunction

endpackage

// File: rtl/wb_sram_slave_if.sv
// Wishbone B3 bus bundle between the cpu initiator and the SRAM responder.
// err_o exists only when WB_SRAM_ERR_EN is defined.
interface wb_sram_slave_if;

  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        stb_i;
  logic        cyc_i;
  logic        ack_o;
  logic [2:0]  cti_i;
  logic [1:0]  bte_i;
  logic        we_i;
  logic [3:0]  sel_i;
`ifdef WB_SRAM_ERR_EN
  logic        err_o;

  modport slave (
    input  adr_i, dat_i, stb_i, cyc_i, cti_i, bte_i, we_i, sel_i,
    output dat_o, ack_o, err_o
  );

  modport master (
    output adr_i, dat_i, stb_i, cyc_i, cti_i, bte_i, we_i, sel_i,
    input  dat_o, ack_o, err_o
  );
`else
  modport slave (
    input  adr_i, dat_i, stb_i, cyc_i, cti_i, bte_i, we_i, sel_i,
    output dat_o, ack_o
  );

  modport master (
    output adr_i, dat_i, stb_i, cyc_i, cti_i, bte_i, we_i, sel_i,
    input  dat_o, ack_o
  );
`endif

endinterface

// File: rtl/sram_be.sv
// Synchronous 32-bit RAM with per-byte write enables and a registered read
// (old data on a same-address collision).
module sram_be #(
  parameter int    AW        = 12,
  parameter string INIT_FILE = ""
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:(1<<AW)-1];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    r_rdata <= r_mem[i_raddr];
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B3 SRAM responder: classic, constant and incrementing bursts with
// linear/wrapped sequences. WB_SRAM_ERR_EN adds err_o for misses and overruns.
//   state | meaning
//   IDLE  | no beat in flight, waiting for a hit
//   ACK   | beat in flight, ack_o high
//   WAIT  | master paused stb_i mid-burst, re-reading held counter
//   ERR   | err_o high for one cycle
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter string       INIT_FILE  = ""
) (
  input  logic          clock_i,
  input  logic          reset_i,
  wb_sram_slave_if.slave bus
);

  localparam int AW = DEPTH_LOG2;

  wb_state_e   r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt, w_adr_idx, w_rd_idx, w_burst_idx;
  logic [31:0] w_burst_full;
  logic        w_req, w_hit, w_beat, w_we;
  logic [31:0] w_ram_q, w_rdata, r_dat_hold, r_byp_dat;
  logic [3:0]  r_byp_sel;
  logic        r_byp_en;
  logic        w_unused;

  assign w_req        = bus.cyc_i & bus.stb_i;
  assign w_hit        = w_req & (bus.adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign w_adr_idx    = bus.adr_i[AW+1:2];
  assign w_beat       = (r_state == ACK) & w_req;
  assign w_we         = w_beat & bus.we_i & ~reset_i;
  assign w_burst_full = next_burst_addr(32'(r_cnt), bus.bte_i);
  assign w_burst_idx  = w_burst_full[AW-1:0];
  assign w_unused     = ^{bus.adr_i[1:0], w_burst_full[31:AW]};

`ifdef WB_SRAM_ERR_EN
  logic w_lin_edge;
  assign w_lin_edge = (bus.bte_i == BTE_LINEAR) & (&r_cnt);
  assign bus.err_o  = (r_state == ERR);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_idx    = r_cnt;
    case (r_state)
      IDLE: begin
        w_rd_idx = w_adr_idx;
        if (w_hit) begin
          w_state_nxt = ACK;
          w_cnt_nxt   = w_adr_idx;
`ifdef WB_SRAM_ERR_EN
          if (bus.sel_i == 4'b0000) w_state_nxt = ERR;
        end else if (w_req) begin
          w_state_nxt = ERR;
`endif
        end
      end
      ACK: begin
        if (!bus.cyc_i) begin
          w_state_nxt = IDLE;
        end else if (!bus.stb_i) begin
          w_state_nxt = WAIT;
        end else if (bus.cti_i == CTI_CONST) begin
          w_state_nxt = ACK;
        end else if (bus.cti_i == CTI_INCR) begin
          // read the successor now so its data is ready for the next beat
          w_state_nxt = ACK;
          w_cnt_nxt   = w_burst_idx;
          w_rd_idx    = w_burst_idx;
`ifdef WB_SRAM_ERR_EN
          if (w_lin_edge) w_state_nxt = ERR;
`endif
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (!bus.cyc_i)     w_state_nxt = IDLE;
        else if (bus.stb_i) w_state_nxt = ACK;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_dat_hold <= '0;
      r_byp_en   <= 1'b0;
      r_byp_dat  <= '0;
      r_byp_sel  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      if (r_state == ACK) r_dat_hold <= w_rdata;
      // RAM returns old data on a collision, so remember the written lanes
      r_byp_en  <= w_we & (r_cnt == w_rd_idx);
      r_byp_dat <= bus.dat_i;
      r_byp_sel <= bus.sel_i;
    end
  end

  always_comb begin
    w_rdata = w_ram_q;
    for (int b = 0; b < 4; b++) begin
      if (r_byp_en && r_byp_sel[b]) w_rdata[8*b +: 8] = r_byp_dat[8*b +: 8];
    end
  end

  assign bus.ack_o = (r_state == ACK);
  assign bus.dat_o = (r_state == ACK) ? w_rdata : r_dat_hold;

  sram_be #(
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .i_clk   (clock_i),
    .i_we    (w_we),
    .i_be    (bus.sel_i),
    .i_waddr (r_cnt),
    .i_wdata (bus.dat_i),
    .i_raddr (w_rd_idx),
    .o_rdata (w_ram_q)
  );

endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: directed cases plus randomized classic and burst
// traffic checked against a word-array memory model.
module tb_wb_sram_slave;
  import wb_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_sram_slave_if bus();

  wb_sram_slave #(
    .DEPTH_LOG2 (AW),
    .BASE_ADDR  (32'h0000_0000),
    .INIT_FILE  ("")
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.sel_i = 4'h0;
    bus.cti_i = CTI_CLASSIC; bus.bte_i = BTE_LINEAR; bus.adr_i = '0; bus.dat_i = '0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  function automatic int next_idx(input int a, input int bte, input bit incr);
    int n;
    if (!incr) return a;
    n = (bte == 0) ? DEPTH : (2 << bte);
    return (a / n) * n + ((a % n) + 1) % n;
  endfunction

  task automatic classic(input int idx, input bit w, input logic [31:0] d,
                         input logic [3:0] s, input string tag);
    bus.adr_i = 32'(idx) << 2; bus.dat_i = d; bus.sel_i = s; bus.we_i = w;
    bus.cti_i = CTI_CLASSIC; bus.bte_i = BTE_LINEAR; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    tick();
    check({tag, "_ack"}, 32'(bus.ack_o), 32'd1);
    if (!w) check({tag, "_rd"}, bus.dat_o, model[idx]);
    else    model[idx] = merge(model[idx], d, s);
    tick();
    idle_bus();
    check({tag, "_ackdrop"}, 32'(bus.ack_o), 32'd0);
    if (!w) check({tag, "_hold"}, bus.dat_o, model[idx]);
  endtask

  // we_mode: 0 read, 1 full-word write, 2 random, 3 alternate write/read
  task automatic burst(input int idx, input int bte, input bit incr, input int n,
                       input int we_mode, input int gap_beat, input string tag);
    int a;
    bit w;
    logic [31:0] d;
    logic [3:0] s;
    a = idx;
    bus.adr_i = 32'(idx) << 2; bus.bte_i = 2'(bte); bus.we_i = 1'b0;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    bus.cti_i = (n == 1) ? CTI_END : (incr ? CTI_INCR : CTI_CONST);
    tick();
    for (int i = 0; i < n; i++) begin
      case (we_mode)
        0:       w = 1'b0;
        1:       w = 1'b1;
        2:       w = 1'($urandom_range(0, 1));
        default: w = (i % 2 == 0);
      endcase
      d = $urandom;
      s = (we_mode == 1) ? 4'hF : 4'($urandom_range(1, 15));
      bus.we_i = w; bus.dat_i = d; bus.sel_i = s;
      bus.cti_i = (i == n - 1) ? CTI_END : (incr ? CTI_INCR : CTI_CONST);
      check({tag, "_ack"}, 32'(bus.ack_o), 32'd1);
      if (!w) check({tag, "_rd"}, bus.dat_o, model[a]);
      else    model[a] = merge(model[a], d, s);
      tick();
      if (i == n - 1) begin
        check({tag, "_end"}, 32'(bus.ack_o), 32'd0);
      end else begin
        a = next_idx(a, bte, incr);
        if (i + 1 == gap_beat) begin
          bus.stb_i = 1'b0;
          repeat (2) begin
            tick();
            check({tag, "_gap"}, 32'(bus.ack_o), 32'd0);
          end
          bus.stb_i = 1'b1;
          tick();
        end
      end
    end
    idle_bus();
  endtask

  initial begin
    idle_bus();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ack", 32'(bus.ack_o), 32'd0);
    check("rst_dat", bus.dat_o, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ack", 32'(bus.ack_o), 32'd0);

    burst(0, 0, 1'b1, 64, 1, 0, "preload");

    classic(4, 1'b1, 32'hDEADBEEF, 4'hF, "cl_wr");
    classic(4, 1'b0, 32'h0, 4'hF, "cl_rd");
    classic(4, 1'b1, 32'h0000_00AA, 4'h1, "byte_wr");
    classic(4, 1'b0, 32'h0, 4'hF, "byte_rd");
    check("byte_merge", bus.dat_o, 32'hDEADBEAA);

    for (int i = 0; i < 4; i++) classic(8 + i, 1'b1, 32'(i + 1), 4'hF, "seq_wr");
    burst(8, 0, 1'b1, 4, 0, 0, "incr4");
    burst(10, 1, 1'b1, 4, 0, 0, "wrap4");
    burst(8, 0, 1'b1, 5, 0, 2, "stbgap");
    burst(5, 0, 1'b0, 4, 3, 0, "const_byp");
    burst(20, 2, 1'b1, 8, 3, 0, "wrap8_wr");
    burst(33, 3, 1'b1, 16, 2, 5, "wrap16");

    // miss: a write here would alias word 0 if the region decode were wrong
    bus.adr_i = 32'h0001_0000; bus.dat_i = 32'h5A5A_5A5A; bus.sel_i = 4'hF;
    bus.we_i = 1'b1; bus.cti_i = CTI_CLASSIC; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
`ifdef WB_SRAM_ERR_EN
    tick();
    check("miss_err", 32'(bus.err_o), 32'd1);
    check("miss_ack", 32'(bus.ack_o), 32'd0);
    idle_bus();
    tick();
    check("miss_err_drop", 32'(bus.err_o), 32'd0);
`else
    repeat (8) begin
      tick();
      check("miss_noack", 32'(bus.ack_o), 32'd0);
    end
    idle_bus();
    tick();
`endif
    classic(0, 1'b0, 32'h0, 4'hF, "miss_ram");

    // reset during beat 2 of a write burst
    bus.adr_i = 32'h40; bus.bte_i = BTE_LINEAR; bus.cti_i = CTI_INCR;
    bus.we_i = 1'b1; bus.dat_i = 32'h1111_2222; bus.sel_i = 4'hF;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    tick();
    check("rstb_b1_ack", 32'(bus.ack_o), 32'd1);
    model[16] = 32'h1111_2222;
    tick();
    check("rstb_b2_ack", 32'(bus.ack_o), 32'd1);
    bus.dat_i = 32'h3333_4444;
    rst = 1'b1;
    tick();
    check("rstb_ack", 32'(bus.ack_o), 32'd0);
    check("rstb_dat", bus.dat_o, 32'd0);
    rst = 1'b0;
    idle_bus();
    tick();
    classic(16, 1'b0, 32'h0, 4'hF, "rstb_w1");
    classic(17, 1'b0, 32'h0, 4'hF, "rstb_w2");

`ifndef WB_SRAM_ERR_EN
    classic(DEPTH - 1, 1'b1, 32'hCAFE_F00D, 4'hF, "top_wr");
    burst(DEPTH - 1, 0, 1'b1, 3, 0, 0, "lin_wrap");
`endif

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        classic($urandom_range(0, 63), 1'($urandom_range(0, 1)), $urandom,
                4'($urandom_range(1, 15)), "rnd_cl");
      end else begin
        burst($urandom_range(0, 47), $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0),
              $urandom_range(1, 8), 2, $urandom_range(0, 4), "rnd_bu");
      end
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
